// File: rtl/clk_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_cfg_pkg
// Description : Shared state encoding, default timing constants and reset
//               values for the clock-configuration controller.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_cfg_pkg;

    // Controller state encoding
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_PARK    = 3'd1;
    localparam state_t ST_CFG     = 3'd2;
    localparam state_t ST_CHECK   = 3'd3;
    localparam state_t ST_RELEASE = 3'd4;

    // Default timing parameters
    localparam int C_SETTLE_DEFAULT       = 16;
    localparam int C_CHECK_CYCLES_DEFAULT = 256;
    localparam int C_MIN_EDGES_DEFAULT    = 4;

    // Reset values of the multi-bit selects
    localparam logic [1:0] C_ROSC_RST = 2'b11;
    localparam logic [1:0] C_DIV_RST  = 2'b00;

endpackage : clk_cfg_pkg
`default_nettype wire

// File: rtl/clk_cfg_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : clk_cfg_edge_det
// Description : Two-flop synchronizer for the asynchronous xclk toggle plus a
//               delay flop; flags every transition of the synchronized value.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_cfg_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_tgl,
    output logic o_edge
);

    // [0],[1] synchronize, [2] delays by one more cycle for edge compare
    logic [2:0] r_sync;

    // Shift the asynchronous toggle through the synchronizer chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], i_tgl};
        end
    end

    assign o_edge = r_sync[2] ^ r_sync[1];

endmodule : clk_cfg_edge_det
`default_nettype wire

// File: rtl/clk_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_cfg_ctrl
// Description : Sequences a glitch-safe clock-manager reconfiguration:
//               park on ROSC, apply selects, optionally verify xclk activity,
//               then release the final root-mux selection.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_cfg_ctrl
    import clk_cfg_pkg::*;
#(
    parameter int SETTLE       = C_SETTLE_DEFAULT,
    parameter int CHECK_CYCLES = C_CHECK_CYCLES_DEFAULT,
    parameter int MIN_EDGES    = C_MIN_EDGES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_mux0,
    input  logic       i_req_mux1,
    input  logic       i_req_mux2,
    input  logic [1:0] i_req_rosc,
    input  logic [1:0] i_req_div,
    input  logic       i_xclk_tgl,
    output logic       o_sel_mux0,
    output logic       o_sel_mux1,
    output logic       o_sel_mux2,
    output logic [1:0] o_sel_rosc,
    output logic [1:0] o_clk_div,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int SW = $clog2(SETTLE);
    localparam int CW = $clog2(CHECK_CYCLES);

    localparam logic [SW-1:0] C_SET_RELOAD = SW'(SETTLE - 1);
    localparam logic [CW-1:0] C_CHK_RELOAD = CW'(CHECK_CYCLES - 1);
    localparam logic [3:0]    C_MIN_EDGES  = 4'(MIN_EDGES);

    state_t          r_state;
    logic [SW-1:0]   r_set_cnt;
    logic [CW-1:0]   r_chk_cnt;
    logic [3:0]      r_edge_cnt;

    logic            r_cap_mux0;
    logic            r_cap_mux1;
    logic            r_cap_mux2;
    logic [1:0]      r_cap_rosc;
    logic [1:0]      r_cap_div;

    logic            r_sel_mux0;
    logic            r_sel_mux1;
    logic            r_sel_mux2;
    logic [1:0]      r_sel_rosc;
    logic [1:0]      r_clk_div;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_edge;

    clk_cfg_edge_det u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .i_tgl  (i_xclk_tgl),
        .o_edge (w_edge)
    );

    // Sequencer: each state entry reloads its own counter, outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_set_cnt  <= '0;
            r_chk_cnt  <= '0;
            r_edge_cnt <= 4'd0;
            r_cap_mux0 <= 1'b0;
            r_cap_mux1 <= 1'b0;
            r_cap_mux2 <= 1'b0;
            r_cap_rosc <= C_ROSC_RST;
            r_cap_div  <= C_DIV_RST;
            r_sel_mux0 <= 1'b0;
            r_sel_mux1 <= 1'b0;
            r_sel_mux2 <= 1'b0;
            r_sel_rosc <= C_ROSC_RST;
            r_clk_div  <= C_DIV_RST;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_cap_mux0 <= i_req_mux0;
                        r_cap_mux1 <= i_req_mux1;
                        r_cap_mux2 <= i_req_mux2;
                        r_cap_rosc <= i_req_rosc;
                        r_cap_div  <= i_req_div;
                        r_sel_mux0 <= 1'b0;
                        r_set_cnt  <= C_SET_RELOAD;
                        r_state    <= ST_PARK;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_PARK: begin
                    if (r_set_cnt == '0) begin
                        r_sel_mux1 <= r_cap_mux1;
                        r_sel_mux2 <= r_cap_mux2;
                        r_sel_rosc <= r_cap_rosc;
                        r_clk_div  <= r_cap_div;
                        r_set_cnt  <= C_SET_RELOAD;
                        r_state    <= ST_CFG;
                    end else begin
                        r_set_cnt <= r_set_cnt - 1'b1;
                    end
                end
                ST_CFG: begin
                    if (r_set_cnt == '0) begin
                        if (r_cap_mux1) begin
                            r_chk_cnt  <= C_CHK_RELOAD;
                            r_edge_cnt <= 4'd0;
                            r_state    <= ST_CHECK;
                        end else begin
                            r_sel_mux0 <= r_cap_mux0;
                            r_set_cnt  <= C_SET_RELOAD;
                            r_state    <= ST_RELEASE;
                        end
                    end else begin
                        r_set_cnt <= r_set_cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (r_chk_cnt == '0) begin
                        if (r_edge_cnt >= C_MIN_EDGES) begin
                            r_sel_mux0 <= r_cap_mux0;
                            r_set_cnt  <= C_SET_RELOAD;
                            r_state    <= ST_RELEASE;
                        end else begin
                            // xclk dead: fall back to ROSC on both muxes
                            r_sel_mux0 <= 1'b0;
                            r_sel_mux1 <= 1'b0;
                            r_err      <= 1'b1;
                            r_ready    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end else begin
                        r_chk_cnt <= r_chk_cnt - 1'b1;
                        if (w_edge && (r_edge_cnt != 4'd15)) begin
                            r_edge_cnt <= r_edge_cnt + 4'd1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (r_set_cnt == '0) begin
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_set_cnt <= r_set_cnt - 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = r_ready;
    assign o_sel_mux0  = r_sel_mux0;
    assign o_sel_mux1  = r_sel_mux1;
    assign o_sel_mux2  = r_sel_mux2;
    assign o_sel_rosc  = r_sel_rosc;
    assign o_clk_div   = r_clk_div;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule : clk_cfg_ctrl
`default_nettype wire

// File: tb/tb_clk_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_cfg_ctrl
// Description : Directed self-checking bench for clk_cfg_ctrl. Cycle labels
//               t+k count from the accepting edge (t+1 = just after it).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_cfg_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_mux0;
    logic       req_mux1;
    logic       req_mux2;
    logic [1:0] req_rosc;
    logic [1:0] req_div;
    logic       xclk_tgl;
    logic       sel_mux0;
    logic       sel_mux1;
    logic       sel_mux2;
    logic [1:0] sel_rosc;
    logic [1:0] clk_div;
    logic       busy;
    logic       done;
    logic       err;

    int total;
    int bad;
    int rel;
    int tgl_from;
    int tgl_period;
    int tgl_left;

    clk_cfg_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_mux0  (req_mux0),
        .i_req_mux1  (req_mux1),
        .i_req_mux2  (req_mux2),
        .i_req_rosc  (req_rosc),
        .i_req_div   (req_div),
        .i_xclk_tgl  (xclk_tgl),
        .o_sel_mux0  (sel_mux0),
        .o_sel_mux1  (sel_mux1),
        .o_sel_mux2  (sel_mux2),
        .o_sel_rosc  (sel_rosc),
        .o_clk_div   (clk_div),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t+%0d observed=%b expected=%b", tag, rel, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t+%0d observed=%b expected=%b", tag, rel, obs, exp);
        end
    endtask

    // One clock, sample 1 time unit after the edge, optional toggle schedule
    task automatic step();
        @(posedge clk);
        #1;
        rel++;
        if (tgl_left > 0 && rel >= tgl_from && (rel % tgl_period) == 0) begin
            xclk_tgl = ~xclk_tgl;
            tgl_left--;
        end
    endtask

    task automatic goto(input int k);
        while (rel < k) step();
    endtask

    task automatic check_reset_vals(input string tag);
        chk1({tag, "_mux0"},  sel_mux0,  1'b0);
        chk1({tag, "_mux1"},  sel_mux1,  1'b0);
        chk1({tag, "_mux2"},  sel_mux2,  1'b0);
        chk2({tag, "_rosc"},  sel_rosc,  2'b11);
        chk2({tag, "_div"},   clk_div,   2'b00);
        chk1({tag, "_busy"},  busy,      1'b0);
        chk1({tag, "_done"},  done,      1'b0);
        chk1({tag, "_err"},   err,       1'b0);
        chk1({tag, "_ready"}, req_ready, 1'b1);
    endtask

    // Present a request while idle; returns at t+1 with req_valid dropped
    task automatic start(input logic m0, input logic m1, input logic m2,
                         input logic [1:0] ro, input logic [1:0] dv);
        chk1("start_ready", req_ready, 1'b1);
        req_mux0  = m0;
        req_mux1  = m1;
        req_mux2  = m2;
        req_rosc  = ro;
        req_div   = dv;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        rel       = 1;
        req_valid = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; rel = 0;
        tgl_from = 0; tgl_period = 1; tgl_left = 0;
        rst = 1'b1; req_valid = 1'b0; xclk_tgl = 1'b0;
        req_mux0 = 1'b0; req_mux1 = 1'b0; req_mux2 = 1'b0;
        req_rosc = 2'b00; req_div = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("reset");

        // ROSC path: {mux0=1, mux1=0, rosc=01, div=10}
        start(1'b1, 1'b0, 1'b0, 2'b01, 2'b10);
        chk1("s1_park_mux0", sel_mux0, 1'b0);
        chk1("s1_busy", busy, 1'b1);
        chk1("s1_ready_low", req_ready, 1'b0);
        goto(16);
        chk2("s1_rosc_before", sel_rosc, 2'b11);
        goto(17);
        chk2("s1_rosc_cfg", sel_rosc, 2'b01);
        chk2("s1_div_cfg", clk_div, 2'b10);
        goto(32);
        chk1("s1_mux0_before", sel_mux0, 1'b0);
        goto(33);
        chk1("s1_mux0_rel", sel_mux0, 1'b1);
        goto(48);
        chk1("s1_done_early", done, 1'b0);
        goto(49);
        chk1("s1_done", done, 1'b1);
        chk1("s1_err", err, 1'b0);
        chk1("s1_ready_done", req_ready, 1'b1);
        chk1("s1_busy_done", busy, 1'b0);
        goto(50);
        chk1("s1_done_pulse", done, 1'b0);

        // xclk path, toggling every 8 cycles
        start(1'b1, 1'b1, 1'b1, 2'b00, 2'b01);
        tgl_from = 1; tgl_period = 8; tgl_left = 1000;
        goto(17);
        chk1("s2_mux1_cfg", sel_mux1, 1'b1);
        chk1("s2_mux2_cfg", sel_mux2, 1'b1);
        chk2("s2_rosc_cfg", sel_rosc, 2'b00);
        goto(288);
        chk1("s2_mux0_check", sel_mux0, 1'b0);
        chk1("s2_busy_check", busy, 1'b1);
        goto(289);
        chk1("s2_mux0_rel", sel_mux0, 1'b1);
        chk1("s2_no_err", err, 1'b0);
        goto(304);
        chk1("s2_done_early", done, 1'b0);
        goto(305);
        chk1("s2_done", done, 1'b1);
        chk1("s2_mux1_final", sel_mux1, 1'b1);
        tgl_left = 0;
        xclk_tgl = 1'b0;

        // xclk stuck at 0
        start(1'b1, 1'b1, 1'b1, 2'b10, 2'b11);
        goto(288);
        chk1("s3_err_early", err, 1'b0);
        chk1("s3_mux1_check", sel_mux1, 1'b1);
        goto(289);
        chk1("s3_err", err, 1'b1);
        chk1("s3_no_done", done, 1'b0);
        chk1("s3_mux0", sel_mux0, 1'b0);
        chk1("s3_mux1", sel_mux1, 1'b0);
        chk1("s3_mux2", sel_mux2, 1'b1);
        chk2("s3_rosc", sel_rosc, 2'b10);
        chk2("s3_div", clk_div, 2'b11);
        chk1("s3_ready", req_ready, 1'b1);
        chk1("s3_busy", busy, 1'b0);
        goto(290);
        chk1("s3_err_pulse", err, 1'b0);
        chk1("s3_done_after", done, 1'b0);

        // Exactly 3 toggles inside the window
        start(1'b1, 1'b1, 1'b0, 2'b01, 2'b00);
        tgl_from = 100; tgl_period = 20; tgl_left = 3;
        goto(289);
        chk1("s4_err3", err, 1'b1);
        chk1("s4_done3", done, 1'b0);
        goto(290);

        // Exactly 4 toggles inside the window
        start(1'b1, 1'b1, 1'b0, 2'b01, 2'b00);
        tgl_from = 100; tgl_period = 20; tgl_left = 4;
        goto(289);
        chk1("s5_err4", err, 1'b0);
        chk1("s5_mux0_rel4", sel_mux0, 1'b1);
        goto(305);
        chk1("s5_done4", done, 1'b1);
        goto(306);

        // Reset mid-CFG, with req_valid asserted in the reset cycle
        start(1'b1, 1'b0, 1'b1, 2'b10, 2'b01);
        goto(17);
        chk1("s6_mux2_cfg", sel_mux2, 1'b1);
        chk2("s6_rosc_cfg", sel_rosc, 2'b10);
        goto(20);
        rst = 1'b1;
        req_valid = 1'b1;
        step();
        check_reset_vals("s6_rst");
        rst = 1'b0;
        req_valid = 1'b0;
        step();
        chk1("s6_idle_after", busy, 1'b0);

        // Second request held while busy: accepted only in first IDLE cycle
        start(1'b1, 1'b0, 1'b0, 2'b01, 2'b01);
        req_mux0 = 1'b0; req_mux1 = 1'b0; req_mux2 = 1'b1;
        req_rosc = 2'b00; req_div = 2'b11;
        req_valid = 1'b1;
        goto(30);
        chk1("s7_ready_busy", req_ready, 1'b0);
        chk2("s7_rosc_first", sel_rosc, 2'b01);
        chk2("s7_div_first", clk_div, 2'b01);
        goto(49);
        chk1("s7_done", done, 1'b1);
        chk1("s7_ready", req_ready, 1'b1);
        chk1("s7_mux0_first", sel_mux0, 1'b1);
        goto(50);
        req_valid = 1'b0;
        chk1("s7_busy2", busy, 1'b1);
        chk1("s7_park2_mux0", sel_mux0, 1'b0);
        goto(65);
        chk2("s7_rosc_hold", sel_rosc, 2'b01);
        goto(66);
        chk2("s7_rosc2", sel_rosc, 2'b00);
        chk2("s7_div2", clk_div, 2'b11);
        chk1("s7_mux2_2", sel_mux2, 1'b1);
        goto(98);
        chk1("s7_done2", done, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_clk_cfg_ctrl
`default_nettype wire
